kypd_hex_entry: RTL and testbench

- Input-side counterpart to the 4-digit seven-segment display path: scans a 4x4 hex keypad on a Pmod header (columns driven, rows read), debounces and decodes presses, and shifts each accepted hex digit into a 16-bit entry register.
- The 16-bit value has the same format as the 16-bit switch word that the display path consumes, so it can replace sw when feeding the display.
- Sits between the Pmod pins and the display/hex-number logic in the top level.

---
 rtl/kypd_hex_entry.sv | 199 +++++++++++++++++++
 tb/tb_kypd_hex_entry.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/kypd_hex_entry.sv
// 4x4 hex keypad scanner: drives one column low at a time, debounces whole-scan
// frames and shifts each accepted digit into a 16-bit entry word.
module kypd_hex_entry #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] value
);
    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t          state, state_next;
    logic [3:0]      row_meta, row_sync;
    logic [TW-1:0]   tick_cnt;
    logic [1:0]      col_idx;
    logic            tick, frame_done;
    logic [1:0]      low_cnt;
    logic [3:0]      acc_key;
    logic [3:0]      col_lows;
    logic [2:0]      col_ones, low_sum;
    logic [1:0]      low_sat, row_idx;
    logic [3:0]      cur_key, frame_key;
    logic            is_none, is_key;
    logic [3:0]      cand, cand_next;
    logic [CW-1:0]   cnt, cnt_next, cnt_inc;
    logic [3:0]      code_next;
    logic            valid_next, down_next, commit;
    logic [15:0]     value_next;

    function automatic logic [2:0] ones4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign tick       = (tick_cnt == TICK_LAST);
    assign frame_done = tick && (col_idx == 2'd3);
    assign col        = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            col_idx  <= 2'd0;
        end else if (tick) begin
            tick_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Frame classification only needs "0, 1 or many" lows plus the key seen when exactly one.
    always_comb begin
        col_lows  = ~row_sync;
        col_ones  = ones4(col_lows);
        low_sum   = {1'b0, low_cnt} + col_ones;
        low_sat   = (low_sum > 3'd1) ? 2'd2 : low_sum[1:0];
        row_idx   = col_lows[0] ? 2'd0 : col_lows[1] ? 2'd1 : col_lows[2] ? 2'd2 : 2'd3;
        cur_key   = key_map(row_idx, col_idx);
        frame_key = (col_ones == 3'd1) ? cur_key : acc_key;
        is_none   = (low_sum == 3'd0);
        is_key    = (low_sum == 3'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt <= 2'd0;
            acc_key <= 4'h0;
        end else if (tick) begin
            if (col_idx == 2'd3) begin
                low_cnt <= 2'd0;
                acc_key <= 4'h0;
            end else begin
                low_cnt <= low_sat;
                acc_key <= frame_key;
            end
        end
    end

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= 4'h0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            value     <= 16'h0000;
        end else begin
            state     <= state_next;
            cand      <= cand_next;
            cnt       <= cnt_next;
            key_code  <= code_next;
            key_valid <= valid_next;
            key_down  <= down_next;
            value     <= value_next;
        end
    end

    // Debounce decisions happen only at frame completion; clr may act on any cycle.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        code_next  = key_code;
        valid_next = 1'b0;
        down_next  = key_down;
        value_next = value;
        commit     = 1'b0;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (is_key) begin
                        cand_next = frame_key;
                        cnt_next  = CW'(1);
                        if (DEBOUNCE_FRAMES == 1) commit = 1'b1;
                        else state_next = PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (is_key && frame_key == cand) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_DONE) commit = 1'b1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            down_next  = 1'b0;
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = CW'(1);
                            state_next = RELEASE_WAIT;
                        end
                    end
                end
                default: begin
                    if (is_none) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            down_next  = 1'b0;
                            state_next = IDLE;
                            cnt_next   = '0;
                        end
                    end else begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end
                end
            endcase
            if (commit) begin
                code_next  = cand_next;
                valid_next = 1'b1;
                down_next  = 1'b1;
                value_next = {value[11:0], cand_next};
                state_next = HELD;
                cnt_next   = '0;
            end
        end
        if (clr) value_next = 16'h0000;
    end
endmodule

// File: tb/tb_kypd_hex_entry.sv
// Directed bench for kypd_hex_entry: models the keypad matrix and checks scan,
// debounce, entry shifting, clr and asynchronous reset with SCAN_DIV=4, DEBOUNCE_FRAMES=2.
module tb_kypd_hex_entry;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] value;

    logic [15:0] pressed = 16'h0000;
    int          checks = 0;
    int          errors = 0;
    int          pulse_cnt = 0;
    int          exp_pulses = 0;

    kypd_hex_entry #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .value(value)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a closed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) if (key_valid) pulse_cnt++;

    function automatic logic [15:0] key_mask(input logic [3:0] k);
        int p;
        case (k)
            4'h1: p = 0;  4'h2: p = 1;  4'h3: p = 2;  4'hA: p = 3;
            4'h4: p = 4;  4'h5: p = 5;  4'h6: p = 6;  4'hB: p = 7;
            4'h7: p = 8;  4'h8: p = 9;  4'h9: p = 10; 4'hC: p = 11;
            4'h0: p = 12; 4'hF: p = 13; 4'hE: p = 14; default: p = 15;
        endcase
        return 16'h0001 << p;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input int cycles);
        pressed = keys;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] k);
        applyStimulus(key_mask(k), 64);
        applyStimulus(16'h0000, 48);
        exp_pulses++;
    endtask

    initial begin
        // Reset state while held in reset
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_col", {12'h0, col}, 16'h000E);
        checkOutput("rst_value", value, 16'h0000);
        checkOutput("rst_valid", {15'h0, key_valid}, 16'h0000);
        checkOutput("rst_down", {15'h0, key_down}, 16'h0000);
        checkOutput("rst_code", {12'h0, key_code}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Column scan: each column for 4 cycles, repeating every 16
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(posedge clk);
            #1;
            checkOutput("scan_col", {12'h0, col}, {12'h0, ~(4'b0001 << ((i + 1) % 4))});
        end

        // Single key 5: pulse lands exactly after the second frame
        applyStimulus(key_mask(4'h5), 32);
        exp_pulses++;
        checkOutput("k5_valid", {15'h0, key_valid}, 16'h0001);
        checkOutput("k5_code", {12'h0, key_code}, 16'h0005);
        checkOutput("k5_down", {15'h0, key_down}, 16'h0001);
        checkOutput("k5_value", value, 16'h0005);
        applyStimulus(key_mask(4'h5), 1);
        checkOutput("k5_valid_drop", {15'h0, key_valid}, 16'h0000);
        applyStimulus(key_mask(4'h5), 47);
        applyStimulus(16'h0000, 31);
        checkOutput("k5_still_down", {15'h0, key_down}, 16'h0001);
        applyStimulus(16'h0000, 1);
        checkOutput("k5_released", {15'h0, key_down}, 16'h0000);
        applyStimulus(16'h0000, 16);
        checkOutput("k5_pulses", 16'(pulse_cnt), 16'(exp_pulses));

        // Entry and wrap
        press_key(4'h1);
        press_key(4'h2);
        press_key(4'h3);
        press_key(4'hA);
        checkOutput("entry_123A", value, 16'h123A);
        press_key(4'h7);
        checkOutput("wrap_23A7", value, 16'h23A7);
        checkOutput("wrap_code", {12'h0, key_code}, 16'h0007);
        checkOutput("entry_pulses", 16'(pulse_cnt), 16'(exp_pulses));

        // Bounce: one frame only
        applyStimulus(key_mask(4'h8), 16);
        applyStimulus(16'h0000, 48);
        checkOutput("bounce_value", value, 16'h23A7);
        checkOutput("bounce_pulses", 16'(pulse_cnt), 16'(exp_pulses));

        // Two keys together
        applyStimulus(key_mask(4'h1) | key_mask(4'h9), 64);
        applyStimulus(16'h0000, 48);
        checkOutput("multi_value", value, 16'h23A7);
        checkOutput("multi_pulses", 16'(pulse_cnt), 16'(exp_pulses));

        // E held, then roll over to 3 without a full release
        applyStimulus(key_mask(4'hE), 48);
        exp_pulses++;
        applyStimulus(key_mask(4'hE) | key_mask(4'h3), 16);
        applyStimulus(key_mask(4'h3), 48);
        checkOutput("roll_value", value, 16'h3A7E);
        checkOutput("roll_down", {15'h0, key_down}, 16'h0001);
        applyStimulus(16'h0000, 16);
        checkOutput("roll_rel1_down", {15'h0, key_down}, 16'h0001);
        applyStimulus(16'h0000, 16);
        checkOutput("roll_rel2_down", {15'h0, key_down}, 16'h0000);
        checkOutput("roll_pulses", 16'(pulse_cnt), 16'(exp_pulses));
        applyStimulus(key_mask(4'h3), 32);
        exp_pulses++;
        checkOutput("roll_3_valid", {15'h0, key_valid}, 16'h0001);
        checkOutput("roll_3_code", {12'h0, key_code}, 16'h0003);
        applyStimulus(key_mask(4'h3), 16);
        applyStimulus(16'h0000, 48);
        checkOutput("roll_3_value", value, 16'hA7E3);

        // Release glitch on key 6
        applyStimulus(key_mask(4'h6), 48);
        exp_pulses++;
        applyStimulus(16'h0000, 16);
        applyStimulus(key_mask(4'h6), 48);
        checkOutput("glitch_down", {15'h0, key_down}, 16'h0001);
        checkOutput("glitch_pulses", 16'(pulse_cnt), 16'(exp_pulses));
        applyStimulus(16'h0000, 48);
        checkOutput("glitch_released", {15'h0, key_down}, 16'h0000);
        checkOutput("glitch_value", value, 16'h7E36);

        // clr alone, then clr coincident with a commit
        clr = 1'b1;
        applyStimulus(16'h0000, 16);
        clr = 1'b0;
        checkOutput("clr_value", value, 16'h0000);
        press_key(4'hA);
        press_key(4'hB);
        checkOutput("clr_pre_AB", value, 16'h00AB);
        applyStimulus(key_mask(4'h4), 31);
        clr = 1'b1;
        applyStimulus(key_mask(4'h4), 1);
        clr = 1'b0;
        exp_pulses++;
        checkOutput("clr_commit_value", value, 16'h0000);
        checkOutput("clr_commit_valid", {15'h0, key_valid}, 16'h0001);
        checkOutput("clr_commit_code", {12'h0, key_code}, 16'h0004);
        checkOutput("clr_commit_down", {15'h0, key_down}, 16'h0001);
        applyStimulus(key_mask(4'h4), 32);
        applyStimulus(16'h0000, 48);
        press_key(4'h9);
        checkOutput("pre_rst_value", value, 16'h0009);

        // Asynchronous reset in the middle of PRESS_WAIT
        applyStimulus(key_mask(4'h2), 16);
        applyStimulus(key_mask(4'h2), 5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_col", {12'h0, col}, 16'h000E);
        checkOutput("async_value", value, 16'h0000);
        checkOutput("async_code", {12'h0, key_code}, 16'h0000);
        checkOutput("async_down", {15'h0, key_down}, 16'h0000);
        checkOutput("async_valid", {15'h0, key_valid}, 16'h0000);
        repeat (3) @(negedge clk);
        pressed = 16'h0000;
        rst_n = 1'b1;
        applyStimulus(16'h0000, 64);
        checkOutput("post_rst_pulses", 16'(pulse_cnt), 16'(exp_pulses));
        checkOutput("post_rst_value", value, 16'h0000);
        applyStimulus(key_mask(4'hD), 32);
        exp_pulses++;
        checkOutput("post_rst_valid", {15'h0, key_valid}, 16'h0001);
        checkOutput("post_rst_code", {12'h0, key_code}, 16'h000D);
        checkOutput("post_rst_keyval", value, 16'h000D);
        applyStimulus(key_mask(4'hD), 16);
        applyStimulus(16'h0000, 48);
        checkOutput("final_pulses", 16'(pulse_cnt), 16'(exp_pulses));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
